// File: rtl/zap_instr_fetch_ctrl_pkg.sv
// zap_instr_fetch_ctrl_pkg -- shared types and helpers for the instruction fetch controller. Rev 1.0
`default_nettype none

package zap_instr_fetch_ctrl_pkg;

`include "zap_localparams.vh"

  typedef enum logic [1:0] {
    S_IDLE  = ZAP_FETCH_IDLE,
    S_FETCH = ZAP_FETCH_FETCH,
    S_DRAIN = ZAP_FETCH_DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus_8;
    logic        abt;
    logic        irq;
    logic        fiq;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Thumb fetches return a whole word; PC bit 1 picks the halfword that holds the opcode.
  function automatic logic [31:0] zap_pick_instr(input logic [31:0] dat,
                                                 input logic        thumb,
                                                 input logic        hi_half);
    if (!thumb) return dat;
    return hi_half ? {16'h0000, dat[31:16]} : {16'h0000, dat[15:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/zap_fetch_skid.sv
// zap_fetch_skid -- one-entry skid buffer holding a fetched instruction while decode stalls. Rev 1.0
`default_nettype none

module zap_fetch_skid
  import zap_instr_fetch_ctrl_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_clear,
  input  logic         i_push,
  input  logic         i_pop,
  input  fetch_entry_t i_data,
  output logic         o_full,
  output fetch_entry_t o_data
);

  logic         full_q, full_d;
  fetch_entry_t data_q, data_d;

  // Clear wins over push so a flushed pipeline never resurrects a stale opcode.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (i_clear) begin
      full_d = 1'b0;
    end else if (i_push) begin
      full_d = 1'b1;
      data_d = i_data;
    end else if (i_pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign o_full = full_q;
  assign o_data = data_q;

endmodule

`default_nettype wire

// File: rtl/zap_localparams.vh
// Shared fetch-FSM state encodings for the ZAP instruction fetch path.
`ifndef ZAP_LOCALPARAMS_VH
`define ZAP_LOCALPARAMS_VH
localparam logic [1:0] ZAP_FETCH_IDLE  = 2'd0;
localparam logic [1:0] ZAP_FETCH_FETCH = 2'd1;
localparam logic [1:0] ZAP_FETCH_DRAIN = 2'd2;
`endif

// File: rtl/zap_instr_fetch_ctrl.sv
// zap_instr_fetch_ctrl -- Wishbone classic instruction fetch FSM with decode-side skid buffer. Rev 1.0
`default_nettype none

module zap_instr_fetch_ctrl
  import zap_instr_fetch_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_pc_nxt,
  input  logic        i_thumb,
  input  logic        i_clear,
  input  logic        i_stall,
  input  logic        i_irq,
  input  logic        i_fiq,
  output logic        o_code_stall,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [31:0] o_wb_adr,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_dat,
  output logic        o_valid,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc_plus_8,
  output logic        o_instr_abt,
  output logic        o_irq,
  output logic        o_fiq
);

  fetch_state_e state_q, state_d;
  logic [31:0]  adr_q, adr_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  fetch_entry_t out_q, out_d;

  logic         term, launch, capture;
  logic         skid_full, skid_push, skid_pop;
  fetch_entry_t cap_entry, skid_data;

  always_comb begin
    term    = (state_q == S_FETCH) && (i_wb_ack || i_wb_err);
    launch  = ((state_q == S_IDLE) || term) && !i_stall && !skid_full;
    capture = term && !i_clear;

    cap_entry.instr     = i_wb_err ? 32'h0 : zap_pick_instr(i_wb_dat, i_thumb, pc_q[1]);
    cap_entry.pc_plus_8 = pc_q + (i_thumb ? 32'd4 : 32'd8);
    cap_entry.abt       = i_wb_err;
    cap_entry.irq       = i_irq;
    cap_entry.fiq       = i_fiq;
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_FETCH: begin
        if (term)         state_d = S_IDLE;
        else if (i_clear) state_d = S_DRAIN;
      end
      S_DRAIN: if (i_wb_ack || i_wb_err) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (launch) begin
      state_d = S_FETCH;
      adr_d   = {i_pc_nxt[31:2], 2'b00};
      pc_d    = i_pc_nxt;
    end
  end

  // Skid content always drains to the output before any newer response.
  always_comb begin
    valid_d   = valid_q;
    out_d     = out_q;
    skid_push = 1'b0;
    skid_pop  = 1'b0;
    if (i_clear) begin
      valid_d = 1'b0;
    end else if (!i_stall) begin
      if (skid_full) begin
        out_d     = skid_data;
        valid_d   = 1'b1;
        skid_pop  = 1'b1;
        skid_push = capture;
      end else if (capture) begin
        out_d   = cap_entry;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (capture) begin
      if (!valid_q) begin
        out_d   = cap_entry;
        valid_d = 1'b1;
      end else begin
        skid_push = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      adr_q   <= 32'h0;
      pc_q    <= 32'h0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  zap_fetch_skid u_skid (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (i_clear),
    .i_push    (skid_push),
    .i_pop     (skid_pop),
    .i_data    (cap_entry),
    .o_full    (skid_full),
    .o_data    (skid_data)
  );

  assign o_code_stall  = !term;
  assign o_wb_cyc      = (state_q != S_IDLE);
  assign o_wb_stb      = (state_q != S_IDLE);
  assign o_wb_adr      = adr_q;
  assign o_valid       = valid_q;
  assign o_instruction = out_q.instr;
  assign o_pc_plus_8   = out_q.pc_plus_8;
  assign o_instr_abt   = out_q.abt;
  assign o_irq         = out_q.irq;
  assign o_fiq         = out_q.fiq;

endmodule

`default_nettype wire

// File: tb/tb_zap_instr_fetch_ctrl.sv
// tb_zap_instr_fetch_ctrl -- directed scenarios plus randomized bus/stall traffic against an in-order scoreboard.
`default_nettype none

module tb_zap_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_nxt = 32'h0;
  logic        thumb = 1'b0, clear = 1'b0, stall = 1'b0, irq = 1'b0, fiq = 1'b0;
  logic        ack = 1'b0, err = 1'b0;
  logic [31:0] dat = 32'h0;

  logic        code_stall, wb_cyc, wb_stb, valid, instr_abt, o_irq_w, o_fiq_w;
  logic [31:0] wb_adr, instruction, pc_plus_8;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic        abt;
    logic        irq;
    logic        fiq;
  } exp_t;

  always #5 clk = ~clk;

  zap_instr_fetch_ctrl dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_pc_nxt      (pc_nxt),
    .i_thumb       (thumb),
    .i_clear       (clear),
    .i_stall       (stall),
    .i_irq         (irq),
    .i_fiq         (fiq),
    .o_code_stall  (code_stall),
    .o_wb_cyc      (wb_cyc),
    .o_wb_stb      (wb_stb),
    .o_wb_adr      (wb_adr),
    .i_wb_ack      (ack),
    .i_wb_err      (err),
    .i_wb_dat      (dat),
    .o_valid       (valid),
    .o_instruction (instruction),
    .o_pc_plus_8   (pc_plus_8),
    .o_instr_abt   (instr_abt),
    .o_irq         (o_irq_w),
    .o_fiq         (o_fiq_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear = 0; stall = 0; irq = 0; fiq = 0; ack = 0; err = 0; dat = 0; thumb = 0;
    rst_n = 0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    irq = 1; fiq = 1; ack = 1; dat = 32'hFFFF_FFFF; pc_nxt = 32'hFFFF_FFFF;
    rst_n = 0;
    tick();
    tick();
    n_checks++; if (valid !== 1'b0)           $display("FAIL reset_valid got=%0h exp=0", valid); else n_pass++;
    n_checks++; if ({wb_cyc, wb_stb} !== 2'b00) $display("FAIL reset_cyc_stb got=%0b exp=00", {wb_cyc, wb_stb}); else n_pass++;
    n_checks++; if (wb_adr !== 32'h0)         $display("FAIL reset_adr got=%08h exp=00000000", wb_adr); else n_pass++;
    n_checks++; if ({instruction, pc_plus_8} !== 64'h0) $display("FAIL reset_instr_pc got=%08h/%08h exp=0/0", instruction, pc_plus_8); else n_pass++;
    n_checks++; if ({instr_abt, o_irq_w, o_fiq_w} !== 3'b000) $display("FAIL reset_tags got=%03b exp=000", {instr_abt, o_irq_w, o_fiq_w}); else n_pass++;
    ack = 0;
    #1;
    n_checks++; if (code_stall !== 1'b1)      $display("FAIL reset_code_stall got=%0b exp=1", code_stall); else n_pass++;
  endtask

  task automatic test_first_fetch();
    do_reset();
    pc_nxt = 32'h0;
    rst_n = 1;
    tick();
    n_checks++; if (wb_cyc !== 1'b1 || wb_adr !== 32'h0) $display("FAIL first_launch cyc=%0b adr=%08h exp=1/00000000", wb_cyc, wb_adr); else n_pass++;
    n_checks++; if (code_stall !== 1'b1) $display("FAIL first_wait1_stall got=%0b exp=1", code_stall); else n_pass++;
    tick();
    n_checks++; if (code_stall !== 1'b1) $display("FAIL first_wait2_stall got=%0b exp=1", code_stall); else n_pass++;
    tick();
    ack = 1; dat = 32'hE3A0_0001; pc_nxt = 32'h4;
    #1;
    n_checks++; if (code_stall !== 1'b0) $display("FAIL first_ack_stall got=%0b exp=0", code_stall); else n_pass++;
    tick();
    ack = 0;
    #1;
    n_checks++; if (valid !== 1'b1 || instruction !== 32'hE3A0_0001 || pc_plus_8 !== 32'h8)
      $display("FAIL first_capture got=%0b/%08h/%08h exp=1/e3a00001/00000008", valid, instruction, pc_plus_8); else n_pass++;
    n_checks++; if (code_stall !== 1'b1) $display("FAIL first_after_ack_stall got=%0b exp=1", code_stall); else n_pass++;
    // Reset in the middle of the fetch of 0x4, then a stray ack afterwards.
    rst_n = 0;
    tick();
    n_checks++; if (wb_cyc !== 1'b0 || valid !== 1'b0) $display("FAIL midreset_drop cyc=%0b valid=%0b exp=0/0", wb_cyc, valid); else n_pass++;
    rst_n = 1; stall = 1; ack = 1; dat = 32'h1111_1111;
    #1;
    n_checks++; if (code_stall !== 1'b1) $display("FAIL late_ack_stall got=%0b exp=1", code_stall); else n_pass++;
    tick();
    ack = 0;
    n_checks++; if (valid !== 1'b0 || wb_cyc !== 1'b0) $display("FAIL late_ack_ignored valid=%0b cyc=%0b exp=0/0", valid, wb_cyc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    pc_nxt = 32'h100;
    rst_n = 1;
    tick();
    ack = 1; dat = 32'hA000_0100; pc_nxt = 32'h104;
    #1;
    n_checks++; if (wb_adr !== 32'h100 || code_stall !== 1'b0) $display("FAIL b2b_first adr=%08h stall=%0b exp=00000100/0", wb_adr, code_stall); else n_pass++;
    tick();
    ack = 1; dat = 32'hA000_0104; pc_nxt = 32'h108;
    #1;
    n_checks++; if (wb_adr !== 32'h104 || code_stall !== 1'b0) $display("FAIL b2b_second adr=%08h stall=%0b exp=00000104/0", wb_adr, code_stall); else n_pass++;
    n_checks++; if (valid !== 1'b1 || instruction !== 32'hA000_0100 || pc_plus_8 !== 32'h108)
      $display("FAIL b2b_out0 got=%0b/%08h/%08h exp=1/a0000100/00000108", valid, instruction, pc_plus_8); else n_pass++;
    tick();
    ack = 0;
    n_checks++; if (valid !== 1'b1 || instruction !== 32'hA000_0104 || pc_plus_8 !== 32'h10C)
      $display("FAIL b2b_out1 got=%0b/%08h/%08h exp=1/a0000104/0000010c", valid, instruction, pc_plus_8); else n_pass++;
  endtask

  task automatic test_clear_drain();
    do_reset();
    pc_nxt = 32'h80;
    rst_n = 1;
    tick();
    tick();
    clear = 1; pc_nxt = 32'h200;
    tick();
    clear = 0;
    #1;
    n_checks++; if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || code_stall !== 1'b1) $display("FAIL drain_hold cyc=%0b stb=%0b stall=%0b exp=1/1/1", wb_cyc, wb_stb, code_stall); else n_pass++;
    tick();
    ack = 1; dat = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (code_stall !== 1'b1) $display("FAIL drain_ack_stall got=%0b exp=1", code_stall); else n_pass++;
    tick();
    ack = 0;
    n_checks++; if (valid !== 1'b0 || wb_cyc !== 1'b0) $display("FAIL drain_discard valid=%0b cyc=%0b exp=0/0", valid, wb_cyc); else n_pass++;
    tick();
    n_checks++; if (wb_cyc !== 1'b1 || wb_adr !== 32'h200) $display("FAIL drain_refetch cyc=%0b adr=%08h exp=1/00000200", wb_cyc, wb_adr); else n_pass++;
    ack = 1; dat = 32'hC0DE_0200; pc_nxt = 32'h204;
    tick();
    ack = 0;
    n_checks++; if (valid !== 1'b1 || instruction !== 32'hC0DE_0200 || pc_plus_8 !== 32'h208)
      $display("FAIL drain_next_out got=%0b/%08h/%08h exp=1/c0de0200/00000208", valid, instruction, pc_plus_8); else n_pass++;
  endtask

  task automatic test_thumb();
    do_reset();
    thumb = 1; pc_nxt = 32'h1002;
    rst_n = 1;
    tick();
    n_checks++; if (wb_adr !== 32'h1000) $display("FAIL thumb_adr got=%08h exp=00001000", wb_adr); else n_pass++;
    ack = 1; dat = 32'hABCD_1234; pc_nxt = 32'h1004;
    tick();
    ack = 0;
    n_checks++; if (instruction !== 32'h0000_ABCD || pc_plus_8 !== 32'h1006)
      $display("FAIL thumb_out got=%08h/%08h exp=0000abcd/00001006", instruction, pc_plus_8); else n_pass++;
    thumb = 0;
  endtask

  task automatic test_err_and_wrap();
    do_reset();
    pc_nxt = 32'h40;
    rst_n = 1;
    tick();
    err = 1; dat = 32'hFFFF_FFFF; irq = 1; pc_nxt = 32'hFFFF_FFFC;
    tick();
    err = 0; irq = 0;
    n_checks++; if (valid !== 1'b1 || instr_abt !== 1'b1 || instruction !== 32'h0 || o_irq_w !== 1'b1 || pc_plus_8 !== 32'h48)
      $display("FAIL err_entry got=%0b/%0b/%08h/%0b/%08h exp=1/1/0/1/00000048", valid, instr_abt, instruction, o_irq_w, pc_plus_8); else n_pass++;
    ack = 1; dat = 32'h1234_5678; fiq = 1; pc_nxt = 32'h0;
    tick();
    ack = 0; fiq = 0;
    n_checks++; if (pc_plus_8 !== 32'h4 || o_fiq_w !== 1'b1 || instr_abt !== 1'b0 || instruction !== 32'h1234_5678)
      $display("FAIL wrap_entry got=%08h/%0b/%0b/%08h exp=00000004/1/0/12345678", pc_plus_8, o_fiq_w, instr_abt, instruction); else n_pass++;
  endtask

  task automatic test_stall_skid();
    do_reset();
    pc_nxt = 32'h300;
    rst_n = 1;
    tick();
    ack = 1; dat = 32'hAAAA_0300; pc_nxt = 32'h304;
    tick();
    stall = 1; ack = 1; dat = 32'hBBBB_0304; pc_nxt = 32'h308;
    #1;
    n_checks++; if (code_stall !== 1'b0) $display("FAIL skid_ack_stall got=%0b exp=0", code_stall); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      ack = 0;
      n_checks++; if (valid !== 1'b1 || instruction !== 32'hAAAA_0300 || wb_cyc !== 1'b0)
        $display("FAIL skid_hold%0d got=%0b/%08h/cyc%0b exp=1/aaaa0300/cyc0", i, valid, instruction, wb_cyc); else n_pass++;
    end
    stall = 0;
    tick();
    n_checks++; if (valid !== 1'b1 || instruction !== 32'hBBBB_0304 || pc_plus_8 !== 32'h30C)
      $display("FAIL skid_release got=%0b/%08h/%08h exp=1/bbbb0304/0000030c", valid, instruction, pc_plus_8); else n_pass++;
    tick();
    n_checks++; if (valid !== 1'b0 || wb_cyc !== 1'b1 || wb_adr !== 32'h308)
      $display("FAIL skid_resume got=%0b/cyc%0b/%08h exp=0/cyc1/00000308", valid, wb_cyc, wb_adr); else n_pass++;
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        e, got;
    logic [31:0] nxt, cur_pc;
    int          waits, pushed, popped;
    bit          prev_cyc, prev_term, term;
    do_reset();
    nxt = 32'h0000_2000; cur_pc = 32'h0;
    pc_nxt = nxt;
    rst_n = 1;
    prev_cyc = 0; prev_term = 0; waits = 0; pushed = 0; popped = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (wb_cyc && (!prev_cyc || prev_term)) begin
        n_checks++; if (wb_adr !== nxt) $display("FAIL rnd_adr cycle=%0d got=%08h exp=%08h", c, wb_adr, nxt); else n_pass++;
        cur_pc = nxt;
        nxt = nxt + 32'd4;
        waits = $urandom_range(0, 3);
      end
      pc_nxt = nxt;
      prev_cyc = wb_cyc;
      irq = 1'($urandom_range(0, 1));
      fiq = 1'($urandom_range(0, 1));
      dat = $urandom;
      ack = 0; err = 0; term = 0;
      if (wb_cyc && c < 560) begin
        if (waits == 0) begin
          term = 1;
          if ($urandom_range(0, 7) == 0) err = 1; else ack = 1;
        end else begin
          waits--;
        end
      end
      stall = (c < 560) ? ($urandom_range(0, 2) == 0) : 1'b0;
      #1;
      n_checks++; if (code_stall !== !term || wb_stb !== wb_cyc)
        $display("FAIL rnd_handshake cycle=%0d stall=%0b stb=%0b cyc=%0b exp_stall=%0b", c, code_stall, wb_stb, wb_cyc, !term); else n_pass++;
      if (valid && !stall) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL rnd_unexpected cycle=%0d got=%08h exp=none", c, instruction);
        end else begin
          e = q.pop_front();
          popped++;
          got = '{instruction, pc_plus_8, instr_abt, o_irq_w, o_fiq_w};
          if (got !== e) $display("FAIL rnd_entry cycle=%0d got=%08h/%08h/%0b%0b%0b exp=%08h/%08h/%0b%0b%0b",
                                  c, got.instr, got.pc8, got.abt, got.irq, got.fiq, e.instr, e.pc8, e.abt, e.irq, e.fiq);
          else n_pass++;
        end
      end
      if (term) begin
        q.push_back('{err ? 32'h0 : dat, cur_pc + 32'd8, err, irq, fiq});
        pushed++;
      end
      prev_term = term;
    end
    ack = 0; err = 0;
    n_checks++; if (q.size() != 0 || pushed != popped || pushed < 50)
      $display("FAIL rnd_drain left=%0d pushed=%0d popped=%0d exp=0/equal/>=50", q.size(), pushed, popped); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_clear_drain();
    test_thumb();
    test_err_and_wrap();
    test_stall_skid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
